// File: rtl/packer_pkg.sv
// Shared definitions for the fixed-point to IEEE-754 single packer:
// float field widths, the FSM state encoding and the float zero constant.
package packer_pkg;

    localparam int FP_BIAS   = 127;
    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    // Conversion sequence; one state per processing step.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ABS   = 3'd1,
        ST_NORM  = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Biased exponent of a magnitude whose leading one sits at bit 31,
    // given the number of fractional bits of the fixed-point input.
    function automatic logic [FP_EXP_W-1:0] start_exp(input int frac_bits);
        return FP_EXP_W'(FP_BIAS + 31 - frac_bits);
    endfunction

endpackage

// File: rtl/packer_round_nearest_even.sv
// Round-to-nearest-even of a normalised magnitude (hidden bit removed) to a
// 23-bit mantissa. A carry out of the mantissa bumps the exponent.
module round_nearest_even
    import packer_pkg::*;
(
    input  logic [30:0]          i_mag,
    input  logic [FP_EXP_W-1:0]  i_exp,
    output logic [FP_EXP_W-1:0]  o_exp,
    output logic [FP_MANT_W-1:0] o_mant
);

    logic [FP_MANT_W-1:0] w_mant;
    logic                 w_guard;
    logic                 w_sticky;
    logic                 w_round_up;
    logic [FP_MANT_W:0]   w_sum;

    assign w_mant     = i_mag[30:8];
    assign w_guard    = i_mag[7];
    assign w_sticky   = |i_mag[6:0];
    // Ties (guard set, sticky clear) round toward an even mantissa.
    assign w_round_up = w_guard & (w_sticky | w_mant[0]);
    assign w_sum      = {1'b0, w_mant} + {{FP_MANT_W{1'b0}}, w_round_up};

    // Apply the rounding increment and fold a mantissa carry into the exponent.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_exp  = i_exp;
        o_mant = w_sum[FP_MANT_W-1:0];
        if (w_sum[FP_MANT_W]) begin
            o_exp  = i_exp + FP_EXP_W'(1);
            o_mant = '0;
        end
    end

endmodule

// File: rtl/packer.sv
// Converts a signed fixed-point value (FRAC_BITS fractional bits) into an
// IEEE-754 single. Multi-cycle: take magnitude, normalise one bit per cycle,
// round to nearest even, then pulse done for one enabled cycle.
module packer
    import packer_pkg::*;
#(
    parameter int FRAC_BITS = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done
);

    localparam logic [FP_EXP_W-1:0] EXP_INIT = start_exp(FRAC_BITS);

    state_t               r_state;
    state_t               w_next_state;
    logic [31:0]          r_data;
    logic                 r_sign;
    logic [31:0]          r_mag;
    logic [FP_EXP_W-1:0]  r_exp;
    logic [31:0]          r_result;

    logic [31:0]          w_abs;
    logic                 w_abs_zero;
    logic [FP_EXP_W-1:0]  w_rne_exp;
    logic [FP_MANT_W-1:0] w_rne_mant;

    // The most negative input maps onto itself, which is its correct unsigned magnitude.
    assign w_abs      = r_data[31] ? (~r_data + 32'd1) : r_data;
    assign w_abs_zero = (w_abs == 32'd0);

    round_nearest_even u_round (
        .i_mag  (r_mag[30:0]),
        .i_exp  (r_exp),
        .o_exp  (w_rne_exp),
        .o_mant (w_rne_mant)
    );

    // State register; clk_en low freezes the sequence.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            r_state <= ST_IDLE;
        end else if (clk_en) begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next_state = ST_ABS;
            ST_ABS:   w_next_state = w_abs_zero ? ST_DONE : ST_NORM;
            ST_NORM:  if (r_mag[31]) w_next_state = ST_ROUND;
            ST_ROUND: w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Datapath: capture, magnitude/exponent setup, normalising shift, result.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the data registers are reset too, so an aborted conversion leaves nothing stale visible.
        if (reset) begin
            r_data   <= '0;
            r_sign   <= 1'b0;
            r_mag    <= '0;
            r_exp    <= '0;
            r_result <= FP_ZERO;
        end else if (clk_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (start) r_data <= dataa;
                end
                ST_ABS: begin
                    r_sign <= r_data[31];
                    r_mag  <= w_abs;
                    r_exp  <= EXP_INIT;
                    if (w_abs_zero) r_result <= FP_ZERO;
                end
                ST_NORM: begin
                    if (!r_mag[31]) begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - FP_EXP_W'(1);
                    end
                end
                ST_ROUND: begin
                    r_result <= {r_sign, w_rne_exp, w_rne_mant};
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign done   = (r_state == ST_DONE);

endmodule

// File: tb/tb_packer.sv
// Self-checking bench for packer: directed vectors, randomized operands against
// an arithmetic float model, start re-assertion, reset abort and clk_en stalls.
module tb_packer;

    localparam int FRAC_BITS = 30;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] result;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    packer #(.FRAC_BITS(FRAC_BITS)) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .dataa  (dataa),
        .result (result),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference: value = d * 2^-FRAC_BITS, rounded to nearest-even single.
    // Latency in enabled cycles is 3 + leading zeros, or 1 for zero.
    function automatic void model(input logic [31:0] d, output logic [31:0] r, output int n);
        bit [63:0] mag;
        bit [63:0] q;
        bit [63:0] rem;
        bit [63:0] half;
        int        p;
        int        e;
        int        sh;
        mag = {32'd0, d};
        if (d[31]) mag = 64'h1_0000_0000 - mag;
        if (mag == 0) begin
            r = 32'h0;
            n = 1;
            return;
        end
        p = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) p = i;
        e = p - FRAC_BITS + 127;
        if (p > 23) begin
            sh   = p - 23;
            q    = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end else begin
            q = mag << (23 - p);
        end
        r = {d[31], 8'(e), q[22:0]};
        n = 3 + (31 - p);
    endfunction

    // One conversion from IDLE; optional stalls in NORM / DONE and a stray start pulse.
    task automatic convert(input logic [31:0] d, input logic [31:0] want_r, input int want_n,
                           input bit stall_norm, input bit stall_done, input bit poke,
                           input string tag);
        int n;
        int sc;
        bit seen;
        @(negedge clk);
        clk_en = 1'b1;
        start  = 1'b1;
        dataa  = d;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dataa = $urandom;
        n = 0;
        sc = 0;
        seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (stall_norm && n == 1 && sc < 5) begin
                clk_en = 1'b0;
                sc++;
            end else begin
                clk_en = 1'b1;
            end
            start = poke && (n == 2);
            if (start) dataa = $urandom;
            @(posedge clk);
            if (clk_en) n++;
            @(negedge clk);
        end
        clk_en = 1'b1;
        start  = 1'b0;
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(want_n));
        check({tag, "_result"}, result, want_r);
        if (stall_done) begin
            clk_en = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                @(negedge clk);
                check({tag, "_stall_done"}, {31'd0, done}, 32'd1);
            end
            check({tag, "_stall_result"}, result, want_r);
            clk_en = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_done_low"}, {31'd0, done}, 32'd0);
        end
        check({tag, "_held"}, result, want_r);
    endtask

    typedef struct {
        logic [31:0] d;
        logic [31:0] r;
        int          n;
    } vec_t;

    vec_t vecs[9] = '{
        '{32'h4000_0000, 32'h3F80_0000, 4},
        '{32'hC000_0000, 32'hBF80_0000, 4},
        '{32'h2000_0000, 32'h3F00_0000, 5},
        '{32'h0000_0001, 32'h3080_0000, 34},
        '{32'h0000_0000, 32'h0000_0000, 1},
        '{32'h8000_0000, 32'hC000_0000, 3},
        '{32'h7FFF_FFFF, 32'h4000_0000, 4},
        '{32'h4000_0040, 32'h3F80_0000, 4},
        '{32'h4000_00C0, 32'h3F80_0002, 4}
    };

    initial begin
        logic [31:0] mr;
        logic [31:0] v;
        int          mn;
        int          next_acc;
        int          done_at;
        logic [31:0] held_r;

        reset  = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        dataa  = '0;
        repeat (2) @(negedge clk);
        check("reset_result", result, 32'h0);
        check("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) convert(vecs[i].d, vecs[i].r, vecs[i].n, 1'b0, 1'b0, 1'b0, "dir");

        convert(32'h4000_0000, 32'h3F80_0000, 4, 1'b1, 1'b1, 1'b0, "stall_one");
        convert(32'h0000_0001, 32'h3080_0000, 34, 1'b1, 1'b1, 1'b1, "stall_tiny");
        convert(32'h2000_0000, 32'h3F00_0000, 5, 1'b0, 1'b0, 1'b1, "poke");

        for (int i = 0; i < 40; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = -v;
            model(v, mr, mn);
            convert(v, mr, mn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), "rand");
        end

        // Reset in the middle of a long NORM phase aborts the conversion.
        @(negedge clk);
        start = 1'b1;
        dataa = 32'h0000_0001;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        convert(32'h4000_0000, 32'h3F80_0000, 4, 1'b0, 1'b0, 1'b0, "after_abort");

        // start held high: a new operand is accepted only when the FSM is idle.
        next_acc = 0;
        done_at  = -1;
        held_r   = '0;
        for (int t = 0; t < 170; t++) begin
            start = (t < 120);
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = -v;
            dataa = v;
            @(posedge clk);
            if (t == next_acc) begin
                if (start) begin
                    model(dataa, held_r, mn);
                    done_at  = t + mn;
                    next_acc = t + mn + 2;
                end else begin
                    next_acc = t + 1;
                end
            end
            @(negedge clk);
            check("held_done", {31'd0, done}, {31'd0, (t == done_at)});
            if (t == done_at) check("held_result", result, held_r);
        end
        start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule

// File: doc/packer.md
Name: packer

Overview:
- Converts a signed two's-complement fixed-point value (Q2.30 by default) into an IEEE-754 single-precision float.
- It is the return path after the CORDIC core: the input unpacker turns floats into fixed-point, and this block turns the fixed-point results back into floats.
- It is multi-cycle. A start/done handshake matches the custom-instruction style. Normalisation is iterative, one bit per cycle, followed by a round-to-nearest-even stage.

Parameters:
- FRAC_BITS, 30, number of fractional bits in the input. Legal range 0..31. Input value = dataa * 2^-FRAC_BITS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- clk_en  input  1  when low, every register holds its value (including done and the FSM).
- start  input  1  single-cycle request; sampled only in IDLE with clk_en high.
- dataa  input  32  signed fixed-point operand; captured on the edge that accepts start.
- result  output  32  IEEE-754 single; valid while done=1, then held until the next accepted start.
- done  output  1  high for exactly one enabled cycle when result is valid.

Behaviour:
- Reset values: result=0, done=0, FSM=IDLE, internal magnitude and exponent registers=0.
- FSM states: IDLE, ABS, NORM, ROUND, DONE. All transitions require clk_en=1.
- IDLE:
  - On start=1, capture dataa and go to ABS.
  - start in any other state is ignored (no queueing).
- ABS:
  - sign = dataa[31]; mag = |dataa| as a 32-bit unsigned value. 0x80000000 gives mag=0x80000000; there is no overflow.
  - exp = 158 - FRAC_BITS.
  - If mag==0: result=0x00000000 (always +0), go to DONE. Otherwise go to NORM.
- NORM:
  - If mag[31]==0: mag <<= 1, exp -= 1, stay in NORM.
  - Otherwise go to ROUND.
  - Let k = leading zeros of mag (0..31). NORM occupies k+1 cycles.
- ROUND:
  - Fields: mant = mag[30:8], guard = mag[7], sticky = |mag[6:0].
  - Round up when guard & (sticky | mant[0]).
  - If rounding carries out of mant: mant=0, exp+=1.
  - result = {sign, exp[7:0], mant}. Go to DONE.
- DONE: done=1 for this cycle only. Next state is IDLE. done=0 on every other cycle.
- Latency: done is high in the cycle after the n-th enabled edge following the edge that accepted start.
  - Nonzero input: n = 3 + k.
  - Zero input: n = 1.
- Exponent range: with FRAC_BITS=30, exp spans 97..128 (128 only for |x|=2, or after round-up carry). No subnormals, overflow or NaN are possible for legal parameter values.
- Asserting reset mid-operation aborts the conversion: done=0 and result=0 immediately; the pending conversion is lost.
- clk_en low mid-operation freezes the state. The conversion resumes with an identical result and latency measured in enabled cycles.
- clk_en low while in DONE keeps done high until the next enabled edge.

Decomposition:
- Shared header/package holds:
  - FP_BIAS=127, FP_EXP_W=8, FP_MANT_W=23
  - the FSM state encodings (3-bit)
  - the FP zero constant 32'h00000000
- One natural sub-module, round_nearest_even: combinational; inputs mag[30:0] and exp; outputs {exp_out, mant_out}, including the carry handling. It is instantiated by packer.

Test Plan:
- 0x40000000 (1.0) -> result 0x3F800000, done after 4 enabled cycles; 0xC0000000 (-1.0) -> 0xBF800000.
- 0x20000000 -> 0x3F000000; 0x00000001 -> 0x30800000 with k=31 (latency 34); 0x00000000 -> 0x00000000, latency 1; 0x80000000 (-2.0) -> 0xC0000000, latency 3.
- Rounding:
  - 0x7FFFFFFF -> 0x40000000 (mantissa carry bumps the exponent).
  - 0x40000040 -> 0x3F800000 (tie, even, round down).
  - 0x400000C0 -> 0x3F800002 (tie, odd, round up).
- Start re-asserted during NORM, and start held high continuously -> no extra conversions beyond the accepted ones; each done is a single-cycle pulse; result matches the first operand.
- Pulse reset in the middle of NORM -> done=0 and result=0 immediately; a following start with 0x40000000 gives 0x3F800000 at normal latency.
- Toggle clk_en low for 5 cycles during NORM and during DONE -> same result; done stays high while stalled in DONE; latency is unchanged in enabled cycles.
